// File: rtl/avalon_s_ram_if.sv
// Avalon-MM device-side bundle between an upstream host/crossbar (master) and the RAM (slave).
// No readdatavalid: read data is qualified by waitrequest low while read is held.
interface avalon_s_ram_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            avn_read;
  logic            avn_write;
  logic [AW-1:0]   avn_address;
  logic [DW/8-1:0] avn_byte_enable;
  logic [DW-1:0]   avn_writedata;
  logic [DW-1:0]   avn_readdata;
  logic            avn_waitrequest;

  modport master (
    output avn_read, avn_write, avn_address, avn_byte_enable, avn_writedata,
    input  avn_readdata, avn_waitrequest
  );

  modport slave (
    input  avn_read, avn_write, avn_address, avn_byte_enable, avn_writedata,
    output avn_readdata, avn_waitrequest
  );
endinterface

// File: rtl/avalon_s_ram.sv
// On-chip Avalon RAM: request in cycle T completes in T+1+WAIT_CYCLES; waitrequest stalls the host, no pipelining.
// Optional AVN_S_RAM_RANDOM_WAIT_EN adds 0..3 LFSR-chosen wait states per transfer.
module avalon_s_ram #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst_n,
  avalon_s_ram_if.slave avn
);

  localparam int IW = $clog2(DEPTH);
  localparam int BW = DW / 8;
  localparam int CW = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   rdata_q;
  logic            wreq_q;
  logic [CW-1:0]   wait_total;
  logic            req;
  logic            rd_load;

  logic [DW-1:0]   mem [DEPTH];

  logic            unused_addr_bits;
  assign unused_addr_bits = ^{avn.avn_address[AW-1:IW+2], avn.avn_address[1:0]};

`ifdef AVN_S_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  // Taps 16,14,13,11 (1-based) on a left-shifting Fibonacci register.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign wait_total = CW'(WAIT_CYCLES) + CW'(lfsr_q[1:0]);
`else
  assign wait_total = CW'(WAIT_CYCLES);
`endif

  assign req = avn.avn_read | avn.avn_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d   = avn.avn_address[IW+1:2];
          be_d    = avn.avn_byte_enable;
          wdata_d = avn.avn_writedata;
          wr_d    = avn.avn_write;
          if (wait_total == '0) begin
            state_d = ST_ACK;
          end else begin
            cnt_d   = wait_total - CW'(1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A host that abandons its request gets no access at all.
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is captured on entry to ACK so it is stable for the whole ACK cycle.
  assign rd_load = (state_q != ST_ACK) && (state_d == ST_ACK) && !wr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      wreq_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      wreq_q  <= (state_d != ST_ACK);
      if (rd_load) begin
        rdata_q <= mem[idx_d];
      end
    end
  end

  // Write commits at the edge that ends ACK; a reset at that edge drops it.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == ST_ACK && wr_q) begin
      for (int i = 0; i < BW; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign avn.avn_readdata    = rdata_q;
  assign avn.avn_waitrequest = wreq_q;

endmodule

// File: tb/tb_avalon_s_ram.sv
// Scoreboard bench for avalon_s_ram: three instances (WAIT_CYCLES 0, 1, 3) share one request driver selected by sel.
// Each completion is checked for readdata and completion latency against hand-computed values.
module tb_avalon_s_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst3_n;
  logic        rd, wr;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wd;
  int          sel;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          issue;
    int          lat;
  } item_t;

  item_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_s_ram_if #(.DW(32), .AW(32)) if0 ();
  avalon_s_ram_if #(.DW(32), .AW(32)) if1 ();
  avalon_s_ram_if #(.DW(32), .AW(32)) if3 ();

  assign if0.avn_read = (sel == 0) && rd;
  assign if0.avn_write = (sel == 0) && wr;
  assign if0.avn_address = addr;
  assign if0.avn_byte_enable = be;
  assign if0.avn_writedata = wd;
  assign if1.avn_read = (sel == 1) && rd;
  assign if1.avn_write = (sel == 1) && wr;
  assign if1.avn_address = addr;
  assign if1.avn_byte_enable = be;
  assign if1.avn_writedata = wd;
  assign if3.avn_read = (sel == 3) && rd;
  assign if3.avn_write = (sel == 3) && wr;
  assign if3.avn_address = addr;
  assign if3.avn_byte_enable = be;
  assign if3.avn_writedata = wd;

  avalon_s_ram #(.DW(32), .AW(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .avn(if0.slave));
  avalon_s_ram #(.DW(32), .AW(32), .DEPTH(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .avn(if1.slave));
  avalon_s_ram #(.DW(32), .AW(32), .DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .avn(if3.slave));

  logic        m_wreq;
  logic [31:0] m_rdata;
  always_comb begin
    m_wreq  = if1.avn_waitrequest;
    m_rdata = if1.avn_readdata;
    if (sel == 0) begin
      m_wreq  = if0.avn_waitrequest;
      m_rdata = if0.avn_readdata;
    end else if (sel == 3) begin
      m_wreq  = if3.avn_waitrequest;
      m_rdata = if3.avn_readdata;
    end
  end

  // Monitor: every completed transfer pops one expectation.
  always @(negedge clk) begin
    item_t it;
    if ((rd || wr) && !m_wreq) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_completion: cycle %0d on dut%0d, nothing expected", cyc, sel);
      end else begin
        it = q.pop_front();
        if (m_rdata !== it.data) begin
          errors++;
          $display("FAIL %s readdata: got %h expected %h", it.name, m_rdata, it.data);
        end
        checks++;
        if (cyc - it.issue != it.lat) begin
          errors++;
          $display("FAIL %s latency: got %0d expected %0d", it.name, cyc - it.issue, it.lat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the completing edge.
  task automatic xfer(input string name, input int s, input bit do_rd, input bit do_wr,
                      input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                      input logic [31:0] exp, input int lat);
    item_t it;
    bit    done;
    sel  = s;
    rd   = do_rd;
    wr   = do_wr;
    addr = a;
    be   = b;
    wd   = d;
    it.name  = name;
    it.data  = exp;
    it.issue = cyc;
    it.lat   = lat;
    q.push_back(it);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!m_wreq) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: waitrequest stayed %b expected 0 within 20 cycles", name, m_wreq);
      void'(q.pop_back());
    end
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wd = '0; sel = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wreq0", {31'd0, if0.avn_waitrequest}, 32'd1);
    check("rst_rdata0", if0.avn_readdata, 32'd0);
    check("rst_wreq1", {31'd0, if1.avn_waitrequest}, 32'd1);
    check("rst_rdata1", if1.avn_readdata, 32'd0);
    check("rst_wreq3", {31'd0, if3.avn_waitrequest}, 32'd1);
    check("rst_rdata3", if3.avn_readdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_wreq1", {31'd0, if1.avn_waitrequest}, 32'd1);
      check("idle_wreq0", {31'd0, if0.avn_waitrequest}, 32'd1);
    end
    @(posedge clk);
    #1;

    // WAIT_CYCLES=1: 3-cycle transfers; writes leave readdata at its previous value.
    xfer("wr_10", 1, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 2);
    xfer("rd_10", 1, 1, 0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 2);
    // Lanes 0 and 2 replaced: DE AD BE EF -> DE 22 BE 44.
    xfer("wr_be5", 1, 0, 1, 32'h10, 4'b0101, 32'h11223344, 32'hDEADBEEF, 2);
    xfer("rd_be5", 1, 1, 0, 32'h10, 4'hF, 32'h0, 32'hDE22BE44, 2);
    xfer("wr_1000", 1, 0, 1, 32'h1000, 4'hF, 32'hCAFEF00D, 32'hDE22BE44, 2);
    xfer("rd_alias0", 1, 1, 0, 32'h0, 4'hF, 32'h0, 32'hCAFEF00D, 2);
    xfer("wr_be0", 1, 0, 1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'hCAFEF00D, 2);
    xfer("rd_be0", 1, 1, 0, 32'h13, 4'hF, 32'h0, 32'hDE22BE44, 2);
    xfer("rdwr_14", 1, 1, 1, 32'h14, 4'hF, 32'h01020304, 32'hDE22BE44, 2);
    xfer("rd_14", 1, 1, 0, 32'h14, 4'hF, 32'h0, 32'h01020304, 2);

    // WAIT_CYCLES=0: back-to-back transfers, waitrequest 1,0,1,0.
    xfer("w0_0", 0, 0, 1, 32'h0, 4'hF, 32'hA5A5A5A5, 32'h0, 1);
    xfer("w0_4", 0, 0, 1, 32'h4, 4'hF, 32'h5A5A5A5A, 32'h0, 1);
    xfer("r0_0", 0, 1, 0, 32'h0, 4'hF, 32'h0, 32'hA5A5A5A5, 1);
    xfer("r0_4", 0, 1, 0, 32'h4, 4'hF, 32'h0, 32'h5A5A5A5A, 1);

    // WAIT_CYCLES=3: reset in the 2nd WAIT cycle drops the pending write.
    xfer("w3_20", 3, 0, 1, 32'h20, 4'hF, 32'h12345678, 32'h0, 4);
    sel = 3; wr = 1'b1; addr = 32'h20; be = 4'hF; wd = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3_n = 1'b0;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    wr = 1'b0;
    @(negedge clk);
    check("midrst_wreq", {31'd0, if3.avn_waitrequest}, 32'd1);
    check("midrst_rdata", if3.avn_readdata, 32'd0);
    @(posedge clk); #1;
    xfer("r3_20", 3, 1, 0, 32'h20, 4'hF, 32'h0, 32'h12345678, 4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
